// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the video capture write path.
//   video_in_state_t : capture FSM state encoding
//   VIDEO_*          : default frame geometry and packet size
//   INT_CYCLES       : length of the end-of-frame interrupt pulse
//   PIX_CNT_W        : width of the per-frame pixel counter (frames < 2^20 px)
//   cnt_width()      : index width for an n-entry table, never below 1 bit
// -----------------------------------------------------------------------------
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } video_in_state_t;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int VIDEO_NBPACK = 16;
  localparam int INT_CYCLES   = 4;
  localparam int PIX_CNT_W    = 20;

  // A one-entry table still needs a 1-bit index to stay legal.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/video_in_pack.sv
// -----------------------------------------------------------------------------
// video_in_pack
// NBPACK x 8-bit pixel buffer, written one pixel at a time and read back as
// 32-bit words of four consecutive pixels (earliest pixel in bits [31:24]).
// Ports:
//   clk        in   system clock
//   nRST       in   synchronous active-low reset, clears the buffer
//   we_i       in   write strobe for one pixel
//   wr_idx_i   in   pixel slot 0..NBPACK-1
//   wr_data_i  in   pixel value
//   rd_word_i  in   word index 0..NBPACK/4-1
//   rd_data_o  out  packed word {p[4w], p[4w+1], p[4w+2], p[4w+3]}
// -----------------------------------------------------------------------------
module video_in_pack
  import video_pkg::*;
#(
  parameter int  NBPACK = VIDEO_NBPACK,
  localparam int FW     = cnt_width(NBPACK),
  localparam int NW     = NBPACK / 4,
  localparam int WW     = cnt_width(NW)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          we_i,
  input  logic [FW-1:0] wr_idx_i,
  input  logic [7:0]    wr_data_i,
  input  logic [WW-1:0] rd_word_i,
  output logic [31:0]   rd_data_o
);

  // Storing whole words keeps the read port a plain array index.
  logic [31:0]   word_q [NW];
  logic [WW-1:0] wr_word_s;
  logic [1:0]    wr_slot_s;

  assign wr_word_s = WW'(wr_idx_i >> 2);
  assign wr_slot_s = wr_idx_i[1:0];

  // Byte-lane write into the addressed word; slot 0 lands in the top byte.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int k = 0; k < NW; k++) begin
        word_q[k] <= 32'd0;
      end
    end else if (we_i) begin
      case (wr_slot_s)
        2'd0:    word_q[wr_word_s][31:24] <= wr_data_i;
        2'd1:    word_q[wr_word_s][23:16] <= wr_data_i;
        2'd2:    word_q[wr_word_s][15:8]  <= wr_data_i;
        2'd3:    word_q[wr_word_s][7:0]   <= wr_data_i;
        default: word_q[wr_word_s][7:0]   <= wr_data_i;
      endcase
    end else begin
      for (int k = 0; k < NW; k++) begin
        word_q[k] <= word_q[k];
      end
    end
  end

  assign rd_data_o = word_q[rd_word_i];

endmodule

// File: rtl/video_in_write.sv
// -----------------------------------------------------------------------------
// video_in_write
// Capture-side DMA master. Pops 8-bit pixels from the input FIFO, packs
// NBPACK of them, and writes the packet as NBPACK/4 Wishbone single writes
// starting at the frame base address. After WIDTH*HEIGHT pixels it raises a
// 4-cycle interrupt and returns to idle until the next start.
// Ports:
//   clk, nRST     clock, synchronous active-low reset
//   wb_reg_data   frame base byte address (bits [1:0] ignored)
//   wb_reg_ctr    control; rising edge of bit 0 starts a frame
//   interrupt     end-of-frame pulse, INT_CYCLES long
//   p_wb_*        Wishbone master write port
//   empty         FIFO empty flag
//   pixel_in      FIFO head (show-ahead)
//   r_e           FIFO pop, combinational on empty
// -----------------------------------------------------------------------------
module video_in_write
  import video_pkg::*;
#(
  parameter int NBPACK = VIDEO_NBPACK,
  parameter int WIDTH  = VIDEO_WIDTH,
  parameter int HEIGHT = VIDEO_HEIGHT
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  output logic        interrupt,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic        empty,
  input  logic [7:0]  pixel_in,
  output logic        r_e
);

  localparam int FW = cnt_width(NBPACK);
  localparam int NW = NBPACK / 4;
  localparam int WW = cnt_width(NW);

  localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(WIDTH * HEIGHT);
  localparam logic [FW-1:0]        FILL_LAST = FW'(NBPACK - 1);
  localparam logic [WW-1:0]        WORD_LAST = WW'(NW - 1);
  localparam logic [1:0]           INT_LAST  = 2'(INT_CYCLES - 1);

  video_in_state_t      state_q, state_d;
  logic                 old_ctr0_q;
  logic [31:0]          base_q, base_d;
  logic [PIX_CNT_W-1:0] pixel_count_q, pixel_count_d;
  logic [FW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [WW-1:0]        word_cnt_q, word_cnt_d;
  logic [1:0]           int_cnt_q, int_cnt_d;

  logic                 start_s;
  logic                 pop_s;
  logic                 bus_s;
  logic [PIX_CNT_W-1:0] pix_next_s;
  logic [31:0]          pack_word_s;
  logic                 unused_bits_s;

  // Only bit 0 of the control register and bits [31:2] of the base matter.
  assign unused_bits_s = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

  assign start_s    = wb_reg_ctr[0] & ~old_ctr0_q;
  assign pop_s      = (state_q == FILL) & ~empty;
  assign bus_s      = (state_q == WRITE);
  assign pix_next_s = pixel_count_q + PIX_CNT_W'(4);

  // Next-state and counter update for the capture FSM.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    pixel_count_d = pixel_count_q;
    fill_cnt_d    = fill_cnt_q;
    word_cnt_d    = word_cnt_q;
    int_cnt_d     = int_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          base_d        = {wb_reg_data[31:2], 2'b00};
          pixel_count_d = '0;
          fill_cnt_d    = '0;
          word_cnt_d    = '0;
          int_cnt_d     = 2'd0;
          state_d       = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (pop_s) begin
          if (fill_cnt_q == FILL_LAST) begin
            fill_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            fill_cnt_d = fill_cnt_q + FW'(1);
          end
        end else begin
          fill_cnt_d = fill_cnt_q;
        end
      end
      WRITE: begin
        if (p_wb_ACK_I) begin
          pixel_count_d = pix_next_s;
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
            // Decide frame end on the count that includes this word.
            if (pix_next_s == FRAME_PIX) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
            end
          end else begin
            word_cnt_d = word_cnt_q + WW'(1);
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      DONE: begin
        if (int_cnt_q == INT_LAST) begin
          int_cnt_d = 2'd0;
          state_d   = IDLE;
        end else begin
          int_cnt_d = int_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; old_ctr0 resets high so a level held
  // through reset is not mistaken for a start.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      old_ctr0_q    <= 1'b1;
      base_q        <= 32'd0;
      pixel_count_q <= '0;
      fill_cnt_q    <= '0;
      word_cnt_q    <= '0;
      int_cnt_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      old_ctr0_q    <= wb_reg_ctr[0];
      base_q        <= base_d;
      pixel_count_q <= pixel_count_d;
      fill_cnt_q    <= fill_cnt_d;
      word_cnt_q    <= word_cnt_d;
      int_cnt_q     <= int_cnt_d;
    end
  end

  video_in_pack #(
    .NBPACK (NBPACK)
  ) u_pack (
    .clk       (clk),
    .nRST      (nRST),
    .we_i      (pop_s),
    .wr_idx_i  (fill_cnt_q),
    .wr_data_i (pixel_in),
    .rd_word_i (word_cnt_q),
    .rd_data_o (pack_word_s)
  );

  // Bus outputs come straight from registered state and are forced to zero
  // outside WRITE, so a reset drops the cycle at the very next edge.
  assign p_wb_STB_O  = bus_s;
  assign p_wb_CYC_O  = bus_s;
  assign p_wb_WE_O   = bus_s;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_ADR_O  = bus_s ? (base_q + 32'(pixel_count_q)) : 32'd0;
  assign p_wb_DAT_O  = bus_s ? pack_word_s : 32'd0;
  assign interrupt   = (state_q == DONE);
  assign r_e         = pop_s;

endmodule

// File: tb/tb_video_in_write.sv
// -----------------------------------------------------------------------------
// tb_video_in_write
// Directed bench for video_in_write with an 8x4 frame and 16-pixel packets
// (32 pixels, 2 packets, 8 words per frame). A small FIFO model feeds pixels,
// a Wishbone slave model acknowledges with a programmable wait count and logs
// every completed write; expected words are rebuilt from the pixels pushed.
// -----------------------------------------------------------------------------
module tb_video_in_write;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] wb_reg_data;
  logic [31:0] wb_reg_ctr;
  logic        interrupt;
  logic [31:0] p_wb_DAT_O;
  logic        p_wb_ACK_I;
  logic        p_wb_STB_O;
  logic        p_wb_CYC_O;
  logic        p_wb_LOCK_O;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O;
  logic [31:0] p_wb_ADR_O;
  logic        empty;
  logic [7:0]  pixel_in;
  logic        r_e;

  int n_vec = 0;
  int n_err = 0;

  // FIFO model
  logic [7:0] fifo_mem [0:511];
  int head = 0;
  int tail = 0;

  // slave model
  int ack_wait = 0;
  logic ack_force = 1'b0;
  int wcnt = 0;
  int stb_cycles = 0;
  int unstable = 0;
  logic [31:0] hold_adr = 32'd0;
  logic [31:0] hold_dat = 32'd0;
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];

  always #5 clk = ~clk;

  video_in_write #(
    .NBPACK (16),
    .WIDTH  (8),
    .HEIGHT (4)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .wb_reg_data (wb_reg_data),
    .wb_reg_ctr  (wb_reg_ctr),
    .interrupt   (interrupt),
    .p_wb_DAT_O  (p_wb_DAT_O),
    .p_wb_ACK_I  (p_wb_ACK_I),
    .p_wb_STB_O  (p_wb_STB_O),
    .p_wb_CYC_O  (p_wb_CYC_O),
    .p_wb_LOCK_O (p_wb_LOCK_O),
    .p_wb_SEL_O  (p_wb_SEL_O),
    .p_wb_WE_O   (p_wb_WE_O),
    .p_wb_ADR_O  (p_wb_ADR_O),
    .empty       (empty),
    .pixel_in    (pixel_in),
    .r_e         (r_e)
  );

  assign empty      = (head == tail);
  assign pixel_in   = fifo_mem[head[8:0]];
  assign p_wb_ACK_I = ack_force | (p_wb_STB_O & (wcnt == ack_wait));

  // FIFO pop, write log and bus stability tracking.
  always @(posedge clk) begin
    if (r_e && !empty) head <= head + 1;
    if (p_wb_STB_O && p_wb_ACK_I) begin
      log_adr.push_back(p_wb_ADR_O);
      log_dat.push_back(p_wb_DAT_O);
    end
    if (p_wb_STB_O && !p_wb_ACK_I) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (p_wb_STB_O) begin
      stb_cycles <= stb_cycles + 1;
      if (wcnt == 0) begin
        hold_adr <= p_wb_ADR_O;
        hold_dat <= p_wb_DAT_O;
      end else if (p_wb_ADR_O !== hold_adr || p_wb_DAT_O !== hold_dat) begin
        unstable <= unstable + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[tail[8:0]] = first + 8'(i);
      tail++;
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    wb_reg_data = base;
    wb_reg_ctr  = 32'h8000_0001;
    @(negedge clk);
    wb_reg_ctr  = 32'h8000_0000;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!interrupt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " irq seen"}, 32'(interrupt), 32'd1);
    n = 0;
    while (interrupt && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " irq len"}, 32'(n), 32'd4);
    chk({tag, " idle cyc"}, 32'(p_wb_CYC_O), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] base,
                             input int fh, input int ls);
    logic [31:0] ea;
    logic [31:0] ed;
    int p;
    chk({tag, " nwords"}, 32'(log_adr.size() - ls), 32'd8);
    for (int k = 0; k < 8; k++) begin
      p  = fh + 4 * k;
      ea = {base[31:2], 2'b00} + 32'(4 * k);
      ed = {fifo_mem[p[8:0]], fifo_mem[(p + 1) & 511],
            fifo_mem[(p + 2) & 511], fifo_mem[(p + 3) & 511]};
      if (ls + k < log_adr.size()) begin
        chk($sformatf("%s adr%0d", tag, k), log_adr[ls + k], ea);
        chk($sformatf("%s dat%0d", tag, k), log_dat[ls + k], ed);
      end
    end
  endtask

  initial begin
    int fh;
    int ls;
    int sc0;
    int n;
    int bad;

    nRST        = 1'b0;
    wb_reg_ctr  = 32'h1;
    wb_reg_data = 32'h0;
    push_pix(8'h00, 32);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst stb", 32'(p_wb_STB_O), 32'd0);
    chk("rst cyc", 32'(p_wb_CYC_O), 32'd0);
    chk("rst we", 32'(p_wb_WE_O), 32'd0);
    chk("rst re", 32'(r_e), 32'd0);
    chk("rst adr", p_wb_ADR_O, 32'd0);
    chk("rst dat", p_wb_DAT_O, 32'd0);
    chk("rst irq", 32'(interrupt), 32'd0);
    chk("lock", 32'(p_wb_LOCK_O), 32'd0);
    chk("sel", 32'(p_wb_SEL_O), 32'hF);

    // bit 0 held high across reset must not start a frame
    nRST = 1'b1;
    repeat (4) @(negedge clk);
    chk("held ctr no re", 32'(r_e), 32'd0);
    chk("held ctr no pop", 32'(head), 32'd0);
    wb_reg_ctr = 32'h0;
    @(negedge clk);

    // nominal frame
    fh = head; ls = log_adr.size();
    start_frame(32'h1000_0000);
    wait_irq("nominal");
    check_frame("nominal", 32'h1000_0000, fh, ls);
    chk("nominal first", log_dat[ls], 32'h0001_0203);
    chk("nominal last", log_dat[ls + 7], 32'h1C1D_1E1F);
    chk("nominal last adr", log_adr[ls + 7], 32'h1000_001C);

    // unaligned base
    push_pix(8'h40, 32);
    fh = head; ls = log_adr.size();
    start_frame(32'h2000_0003);
    wait_irq("unaligned");
    check_frame("unaligned", 32'h2000_0000, fh, ls);
    chk("unaligned first adr", log_adr[ls], 32'h2000_0000);

    // FIFO underrun after pixel 5
    push_pix(8'h80, 5);
    fh = head; ls = log_adr.size();
    start_frame(32'h0000_0100);
    n = 0;
    while (head != fh + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("underrun reached", 32'(head - fh), 32'd5);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (r_e || p_wb_STB_O) bad++;
    end
    chk("underrun stall quiet", 32'(bad), 32'd0);
    push_pix(8'h85, 27);
    wait_irq("underrun");
    check_frame("underrun", 32'h0000_0100, fh, ls);
    chk("underrun first", log_dat[ls], 32'h8081_8283);

    // wait-state slave with a start toggled during WRITE
    ack_wait = 3;
    push_pix(8'hA0, 32);
    fh = head; ls = log_adr.size(); sc0 = stb_cycles;
    start_frame(32'h1234_5678);
    n = 0;
    while (!p_wb_STB_O && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy stb seen", 32'(p_wb_STB_O), 32'd1);
    wb_reg_ctr  = 32'h1;
    wb_reg_data = 32'h7777_0000;
    @(negedge clk);
    wb_reg_ctr  = 32'h0;
    wait_irq("waitstate");
    check_frame("waitstate", 32'h1234_5678, fh, ls);
    chk("waitstate stable", 32'(unstable), 32'd0);
    chk("waitstate stb cycles", 32'(stb_cycles - sc0), 32'd32);

    // restart after DONE from a new base
    ack_wait = 0;
    push_pix(8'h60, 32);
    fh = head; ls = log_adr.size();
    start_frame(32'h3000_0000);
    wait_irq("restart");
    check_frame("restart", 32'h3000_0000, fh, ls);

    // reset in the middle of word 2
    ack_wait = 3;
    push_pix(8'hC0, 32);
    ls = log_adr.size();
    start_frame(32'h5000_0000);
    n = 0;
    while (!(log_adr.size() == ls + 2 && p_wb_STB_O) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst word2", 32'(log_adr.size() - ls), 32'd2);
    nRST = 1'b0;
    @(negedge clk);
    chk("midrst stb", 32'(p_wb_STB_O), 32'd0);
    chk("midrst cyc", 32'(p_wb_CYC_O), 32'd0);
    chk("midrst we", 32'(p_wb_WE_O), 32'd0);
    chk("midrst adr", p_wb_ADR_O, 32'd0);
    chk("midrst dat", p_wb_DAT_O, 32'd0);
    chk("midrst re", 32'(r_e), 32'd0);
    chk("midrst irq", 32'(interrupt), 32'd0);
    ack_force = 1'b1;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    chk("midrst late ack stb", 32'(p_wb_STB_O), 32'd0);
    ack_force = 1'b0;
    @(negedge clk);
    chk("midrst no extra write", 32'(log_adr.size() - ls), 32'd2);

    ack_wait = 0;
    push_pix(8'hE0, 16);
    fh = head; ls = log_adr.size();
    start_frame(32'h4000_0000);
    wait_irq("fresh");
    check_frame("fresh", 32'h4000_0000, fh, ls);
    chk("fresh first adr", log_adr[ls], 32'h4000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
